// File: rtl/mandelbrot_scheduler_pkg.sv
// Shared types and widths for the Mandelbrot frame scheduler.
//   COORD_W : packed pixel coordinate {x, y}
//   X_W/Y_W : raster counter widths
//   COLOR_W : iteration-colour width
//   state_e : frame controller states
package mandelbrot_scheduler_pkg;

  localparam int COORD_W = 19;
  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int COLOR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [COORD_W-1:0] pack_coord(input logic [X_W-1:0] x,
                                                    input logic [Y_W-1:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/mandelbrot_scheduler_rr_arbiter.sv
// Round-robin arbiter with a rotating pointer.
//   clk, rst : clock, asynchronous active-high reset
//   req      : N request lines
//   en       : grant permitted this cycle
//   gnt      : one-hot grant (zero when en=0 or no request)
// Search starts at the pointer; after a grant the pointer moves to the
// index just past the winner.
module mandelbrot_scheduler_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          hit;
  int            sel;

  // Two passes: indices at/after the pointer first, then wrap to the start.
  always_comb begin
    hit = 1'b0;
    sel = 0;
    for (int i = 0; i < N; i++) begin
      if (!hit && req[i] && (i >= int'(ptr_q))) begin
        hit = 1'b1;
        sel = i;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!hit && req[i]) begin
        hit = 1'b1;
        sel = i;
      end
    end
  end

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    if (en && hit) begin
      for (int i = 0; i < N; i++) gnt[i] = (sel == i);
      ptr_d = (sel == N - 1) ? '0 : PW'(sel + 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mandelbrot_scheduler.sv
// Frame-level controller for a bank of Mandelbrot pixel processors.
// Raster-scans the screen, hands one coordinate per cycle to the lowest
// idle processor, and funnels finished results through a round-robin
// arbiter into single pixel writes toward the frame buffer.
//   clk, reset           : clock, asynchronous active-high reset
//   iStart/oBusy/oDone   : frame control handshake
//   iProcReady/oDataVal/oCoord            : dispatch side
//   iCoordVal/iCoordSig/iColor/oResAck    : result collection side
//   iVgaReady/oWrEn/oWrCoord/oWrColor     : frame-buffer write port
module mandelbrot_scheduler
  import mandelbrot_scheduler_pkg::*;
#(
  parameter int NUM_PROCS = 4,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         iStart,
  output logic                         oBusy,
  output logic                         oDone,
  input  logic [NUM_PROCS-1:0]         iProcReady,
  output logic [NUM_PROCS-1:0]         oDataVal,
  output logic [COORD_W-1:0]           oCoord,
  input  logic [NUM_PROCS-1:0]         iCoordVal,
  input  logic [COORD_W*NUM_PROCS-1:0] iCoordSig,
  input  logic [COLOR_W*NUM_PROCS-1:0] iColor,
  output logic [NUM_PROCS-1:0]         oResAck,
  input  logic                         iVgaReady,
  output logic                         oWrEn,
  output logic [COORD_W-1:0]           oWrCoord,
  output logic [COLOR_W-1:0]           oWrColor
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  state_e               state_q, state_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [NUM_PROCS-1:0] busy_q, busy_d;
  logic                 wr_en_q, wr_en_d;
  logic [COORD_W-1:0]   wr_coord_q, wr_coord_d;
  logic [COLOR_W-1:0]   wr_color_q, wr_color_d;

  logic [NUM_PROCS-1:0] eligible, disp_oh, gnt;
  logic                 disp_hit, coll_en;

  // Lowest-index idle and ready processor.
  assign eligible = iProcReady & ~busy_q;

  always_comb begin
    disp_oh  = '0;
    disp_hit = 1'b0;
    for (int i = 0; i < NUM_PROCS; i++) begin
      if (!disp_hit && eligible[i]) begin
        disp_oh[i] = 1'b1;
        disp_hit   = 1'b1;
      end
    end
  end

  // Only processors we actually dispatched to may be acknowledged.
  assign coll_en = iVgaReady && (state_q == ST_SCAN || state_q == ST_DRAIN);

  mandelbrot_scheduler_rr_arbiter #(.N(NUM_PROCS)) u_res_arb (
    .clk (clk),
    .rst (reset),
    .req (iCoordVal & busy_q),
    .en  (coll_en),
    .gnt (gnt)
  );

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    busy_d     = busy_q & ~gnt;
    wr_en_d    = |gnt;
    wr_coord_d = wr_coord_q;
    wr_color_d = wr_color_q;
    oDataVal   = '0;
    oCoord     = '0;

    for (int i = 0; i < NUM_PROCS; i++) begin
      if (gnt[i]) begin
        wr_coord_d = iCoordSig[i*COORD_W +: COORD_W];
        wr_color_d = iColor[i*COLOR_W +: COLOR_W];
      end
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (iStart) begin
          state_d = ST_SCAN;
          x_d     = '0;
          y_d     = '0;
        end
      end
      ST_SCAN: begin
        if (disp_hit) begin
          oDataVal = disp_oh;
          oCoord   = pack_coord(x_q, y_q);
          busy_d   = busy_d | disp_oh;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) state_d = ST_DRAIN;
            else               y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // Wait for the final write to leave before declaring the frame done.
        if (busy_q == '0 && !wr_en_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      busy_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_coord_q <= '0;
      wr_color_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      wr_coord_q <= wr_coord_d;
      wr_color_q <= wr_color_d;
    end
  end

  assign oResAck  = gnt;
  assign oBusy    = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
  assign oDone    = (state_q == ST_DONE);
  assign oWrEn    = wr_en_q;
  assign oWrCoord = wr_coord_q;
  assign oWrColor = wr_color_q;

endmodule

// File: tb/tb_mandelbrot_scheduler.sv
// Directed bench for mandelbrot_scheduler on a 4x2 screen with two
// processors. A small processor model returns each result 3 cycles after
// dispatch, with colour = linear pixel index.
module tb_mandelbrot_scheduler;
  import mandelbrot_scheduler_pkg::*;

  localparam int NP = 2, HR = 4, VR = 2, NPIX = HR * VR;

  logic clk = 1'b0;
  logic reset, iStart, iVgaReady, oBusy, oDone, oWrEn;
  logic [NP-1:0] iProcReady, oDataVal, iCoordVal, oResAck;
  logic [COORD_W-1:0] oCoord, oWrCoord;
  logic [COORD_W*NP-1:0] iCoordSig;
  logic [COLOR_W*NP-1:0] iColor;
  logic [COLOR_W-1:0] oWrColor;

  mandelbrot_scheduler #(.NUM_PROCS(NP), .H_RES(HR), .V_RES(VR)) dut (
    .clk(clk), .reset(reset), .iStart(iStart), .oBusy(oBusy), .oDone(oDone),
    .iProcReady(iProcReady), .oDataVal(oDataVal), .oCoord(oCoord),
    .iCoordVal(iCoordVal), .iCoordSig(iCoordSig), .iColor(iColor),
    .oResAck(oResAck), .iVgaReady(iVgaReady), .oWrEn(oWrEn),
    .oWrCoord(oWrCoord), .oWrColor(oWrColor)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  logic [NP-1:0] ready_mask, spur, val, pend;
  int cnt[NP];
  logic [COORD_W-1:0] hcoord[NP];
  logic auto_ret, vga, start_pulse;
  logic [NP-1:0] s_disp, s_ack;
  logic [COORD_W-1:0] s_coord;
  logic s_done, s_wren;
  logic [COORD_W-1:0] disp_q[$];
  int gnt_q[$];
  int written[NPIX];

  function automatic logic [COLOR_W-1:0] color_of(input logic [COORD_W-1:0] c);
    return COLOR_W'(int'(c[COORD_W-1:Y_W]) + HR * int'(c[Y_W-1:0]));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    val = '0; pend = '0; s_disp = '0; s_ack = '0; s_coord = '0;
    s_done = 1'b0; s_wren = 1'b0;
    for (int i = 0; i < NP; i++) begin cnt[i] = 0; hcoord[i] = '0; end
  endtask

  // Commit last cycle's sampled events, drive inputs, sample at negedge.
  task automatic tick();
    int wx, wy;
    @(posedge clk); #1;
    for (int i = 0; i < NP; i++) begin
      if (s_ack[i]) begin val[i] = 1'b0; pend[i] = 1'b0; end
      if (s_disp[i]) begin pend[i] = 1'b1; hcoord[i] = s_coord; cnt[i] = 3; end
      else if (cnt[i] > 0) cnt[i]--;
      if (pend[i] && cnt[i] == 0 && auto_ret) val[i] = 1'b1;
    end
    iStart = start_pulse; start_pulse = 1'b0;
    iProcReady = ready_mask; iVgaReady = vga;
    for (int i = 0; i < NP; i++) begin
      iCoordVal[i] = val[i] | spur[i];
      iCoordSig[i*COORD_W +: COORD_W] = val[i] ? hcoord[i] : (spur[i] ? '1 : '0);
      iColor[i*COLOR_W +: COLOR_W] = color_of(hcoord[i]);
    end
    @(negedge clk);
    s_disp = oDataVal; s_coord = oCoord; s_ack = oResAck;
    s_done = oDone; s_wren = oWrEn;
    chk("disp_onehot", 32'($onehot0(oDataVal)), 1);
    chk("ack_onehot", 32'($onehot0(oResAck)), 1);
    if (|oDataVal) disp_q.push_back(oCoord);
    for (int i = 0; i < NP; i++) if (oResAck[i]) gnt_q.push_back(i);
    if (oWrEn) begin
      wx = int'(oWrCoord[COORD_W-1:Y_W]);
      wy = int'(oWrCoord[Y_W-1:0]);
      chk("wr_range", 32'(wx < HR && wy < VR), 1);
      chk("wr_color", 32'(oWrColor), 32'(color_of(oWrCoord)));
      if (wx < HR && wy < VR) written[wx + HR * wy]++;
    end
  endtask

  task automatic start_frame();
    disp_q.delete(); gnt_q.delete();
    for (int p = 0; p < NPIX; p++) written[p] = 0;
    start_pulse = 1'b1;
    tick();
    tick();
  endtask

  task automatic run_frame();
    int t = 0;
    while (!s_done && t < 300) begin tick(); t++; end
    chk("frame_done", 32'(s_done), 1);
    chk("busy_low_in_done", 32'(oBusy), 0);
  endtask

  task automatic check_frame();
    chk("n_disp", disp_q.size(), NPIX);
    for (int k = 0; k < disp_q.size() && k < NPIX; k++)
      chk("disp_order", 32'(disp_q[k]), 32'(pack_coord(X_W'(k % HR), Y_W'(k / HR))));
    chk("n_grant", gnt_q.size(), NPIX);
    for (int p = 0; p < NPIX; p++) chk("pix_once", written[p], 1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1; clear_model();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int t;
    reset = 1'b1; iStart = 1'b0; iVgaReady = 1'b1; iProcReady = '0;
    iCoordVal = '0; iCoordSig = '0; iColor = '0;
    ready_mask = 2'b11; spur = '0; auto_ret = 1'b1; vga = 1'b1; start_pulse = 1'b0;
    clear_model();
    #2;
    chk("rst_busy", 32'(oBusy), 0);
    chk("rst_done", 32'(oDone), 0);
    chk("rst_dataval", 32'(oDataVal), 0);
    chk("rst_coord", 32'(oCoord), 0);
    chk("rst_ack", 32'(oResAck), 0);
    chk("rst_wren", 32'(oWrEn), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_busy", 32'(oBusy), 0);

    // Full frame; an iStart pulse mid-scan must be ignored.
    start_frame();
    chk("scan_busy", 32'(oBusy), 1);
    tick(); tick();
    start_pulse = 1'b1;
    run_frame();
    check_frame();

    // Asynchronous reset when pixel (2,1) is dispatched.
    start_frame();
    t = 0;
    while (!(|s_disp && s_coord == pack_coord(10'd2, 9'd1)) && t < 100) begin tick(); t++; end
    chk("saw_pixel_2_1", 32'(t < 100), 1);
    #1 reset = 1'b1;
    #1;
    chk("arst_busy", 32'(oBusy), 0);
    chk("arst_dataval", 32'(oDataVal), 0);
    chk("arst_coord", 32'(oCoord), 0);
    chk("arst_ack", 32'(oResAck), 0);
    chk("arst_wren", 32'(oWrEn), 0);
    chk("arst_wrcoord", 32'(oWrCoord), 0);
    chk("arst_wrcolor", 32'(oWrColor), 0);
    clear_model();
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_idle", 32'({oBusy, oDone}), 0);
    start_frame();
    run_frame();
    check_frame();

    // Simultaneous results alternate grants, starting from proc0 after reset.
    pulse_reset();
    auto_ret = 1'b0;
    start_frame();
    for (int r = 0; r < 3; r++) begin
      t = 0;
      while (!(pend == 2'b11 && cnt[0] == 0 && cnt[1] == 0) && t < 20) begin tick(); t++; end
      chk("both_held", 32'(t < 20), 1);
      val = 2'b11;
      tick();
      tick();
    end
    chk("alt_count", gnt_q.size(), 6);
    for (int k = 0; k < gnt_q.size() && k < 6; k++) chk("alt_grant", gnt_q[k], k % 2);
    auto_ret = 1'b1;
    run_frame();
    check_frame();

    // iStart in DONE: oDone drops next cycle and (0,0) goes to proc0.
    disp_q.delete(); gnt_q.delete();
    for (int p = 0; p < NPIX; p++) written[p] = 0;
    start_pulse = 1'b1;
    tick();
    chk("done_held_on_start", 32'(oDone), 1);
    tick();
    chk("done_fell", 32'(oDone), 0);
    chk("restart_disp", 32'(oDataVal), 32'(2'b01));
    chk("restart_coord", 32'(oCoord), 0);

    // Frame-buffer stall for 20 cycles in the same frame.
    tick(); tick(); tick();
    vga = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("stall_ack", 32'(s_ack), 0);
      if (k > 0) chk("stall_wren", 32'(s_wren), 0);
    end
    chk("stall_no_disp", 32'(s_disp), 0);
    vga = 1'b1;
    run_frame();
    check_frame();

    // Only proc0 used; proc1 raises results while never dispatched.
    // iStart during DRAIN must be ignored.
    ready_mask = 2'b01; spur = 2'b10;
    start_frame();
    t = 0;
    while (disp_q.size() < NPIX && t < 200) begin tick(); t++; end
    chk("reached_drain", 32'(t < 200), 1);
    start_pulse = 1'b1;
    run_frame();
    tick(); tick(); tick();
    chk("drain_start_ignored", disp_q.size(), NPIX);
    chk("still_done", 32'(oDone), 1);
    check_frame();
    for (int k = 0; k < gnt_q.size(); k++) chk("spur_never_acked", gnt_q[k], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mandelbrot_scheduler.md
Name: mandelbrot_scheduler

Overview:
Frame-level controller for the bank of Mandelbrot pixel processors. It raster-scans the screen and dispatches one pixel coordinate at a time to an idle processor. It collects finished results from all processors through a round-robin arbiter and serialises them into single pixel writes toward the VGA frame buffer. It sits between the start/control logic and the processor array.

Parameters:
NUM_PROCS, 4, number of processor instances served (1..16)
H_RES, 640, pixels per line; x range 0..H_RES-1 (fits 10 bits)
V_RES, 480, lines per frame; y range 0..V_RES-1 (fits 9 bits)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
iStart  in  1  pulse: begin a frame (accepted only in IDLE or DONE)
oBusy  out  1  high from frame start until the last write is issued
oDone  out  1  high in DONE, until the next accepted iStart or reset
iProcReady  in  NUM_PROCS  per-processor ready
oDataVal  out  NUM_PROCS  one-hot dispatch strobe, 1 cycle
oCoord  out  19  shared dispatch coordinate {x[9:0], y[8:0]}
iCoordVal  in  NUM_PROCS  per-processor result valid
iCoordSig  in  19*NUM_PROCS  per-processor result coordinate, processor i at [19i+18:19i]
iColor  in  4*NUM_PROCS  per-processor result colour, processor i at [4i+3:4i]
oResAck  out  NUM_PROCS  one-hot result acknowledge, 1 cycle
iVgaReady  in  1  frame buffer can accept a write this cycle
oWrEn  out  1  pixel write strobe
oWrCoord  out  19  pixel write coordinate
oWrColor  out  4  pixel write colour

Behaviour:
- Reset values: every output is 0; state=IDLE; x=y=0; busy[]=0; rr pointer=0; all dispatched-flags cleared.
- A reset asserted mid-frame abandons the frame. Processors share the same reset, so no state survives.
- States:
  - IDLE: on iStart -> SCAN; x=y=0; oBusy=1.
  - SCAN: dispatch pixels; after the pixel (H_RES-1, V_RES-1) is dispatched -> DRAIN.
  - DRAIN: no dispatch; when busy[]==0 and no write is pending -> DONE.
  - DONE: oDone=1, oBusy=0; iStart -> SCAN with counters cleared and oDone=0.
- Dispatch (SCAN only):
  - Eligible processors: iProcReady[i] & ~busy[i]. Choose the lowest eligible index.
  - Drive oDataVal[i]=1 and oCoord={x,y} for exactly one cycle; set busy[i].
  - At most one dispatch per cycle.
  - Raster advance: x++; at x==H_RES-1, x wraps to 0 and y++. y never exceeds V_RES-1.
- Result collection (SCAN, DRAIN):
  - Requests: iCoordVal[i] & busy[i]. Round-robin starting at the index after the last grant.
  - A grant occurs only when iVgaReady=1.
  - On grant: oResAck[i]=1 for one cycle; clear busy[i]; register the write.
  - Next cycle: oWrEn=1, oWrCoord=iCoordSig slice, oWrColor=iColor slice. Latency from grant to write is 1 cycle.
  - At most one grant per cycle.
- A processor dropping iCoordVal before its ack must not be granted that cycle. Results from processors with busy[i]=0 are ignored and never acked.
- A dispatch and a result grant may occur in the same cycle on different processors. The same processor cannot be both, because busy gates dispatch.
- Throughput: up to 1 dispatch and 1 write per cycle.
- Boundary conditions:
  - iStart during SCAN or DRAIN is ignored.
  - NUM_PROCS=1 is degenerate but legal.
  - iVgaReady held low stalls collection only; dispatch continues until every processor is busy.

Decomposition:
- Shared package: coordinate width (19), x/y field widths (10/9), colour width (4), state encodings (IDLE, SCAN, DRAIN, DONE).
- One sub-module: rr_arbiter (NUM_PROCS-wide request, enable, one-hot grant, rotating pointer). It is reusable for other shared resources.
- Raster counter and dispatch logic stay inline.

Test Plan:
1. NUM_PROCS=2, H_RES=4, V_RES=2, both processors ready, results returned 3 cycles after dispatch with iVgaReady=1 -> 8 dispatches with coords (0,0),(1,0)..(3,1) in order; 8 writes; oDone rises; each pixel written exactly once.
2. Both processors assert iCoordVal in the same cycle, repeatedly -> grants alternate proc0, proc1, proc0...; exactly one oResAck bit per cycle.
3. iVgaReady=0 for 20 cycles mid-frame -> no oResAck or oWrEn; dispatch stops once busy=2'b11; resumes with no lost or duplicated pixel when released.
4. Processor asserts iCoordVal while its busy bit is clear -> never acked; no write produced.
5. reset asserted at pixel (2,1) during SCAN -> all outputs 0 immediately (asynchronous); state IDLE; next iStart restarts at (0,0).
6. iStart pulsed during DRAIN -> ignored; iStart in DONE -> oDone falls the next cycle and dispatch of (0,0) follows.
